// File: rtl/quokka_reset_pkg.sv
// quokka_reset_pkg: shared types for the quokka reset sequencer.
// Sequencer FSM states and ResetCause encodings.
package quokka_reset_pkg;

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2,
    ST_COOL = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_SOFT   = 2'b10;
  localparam logic [1:0] CAUSE_WDT    = 2'b11;

endpackage

// File: rtl/quokka_button_debounce.sv
// quokka_button_debounce: two-flop synchroniser, debounce counter
// and a single-cycle pulse on each debounced 0->1 transition.
module quokka_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q  = 1'b0;
  logic             s2_q  = 1'b0;
  logic             lvl_q = 1'b0;
  logic [CNT_W-1:0] cnt_q = '0;

  logic             lvl_d;
  logic [CNT_W-1:0] cnt_d;
  logic             diff;
  logic             flip;

  assign diff   = s2_q != lvl_q;
  assign flip   = diff && (cnt_q == DB_LAST);
  assign rise_o = flip && s2_q;

  // Any sample matching the current level restarts the stability run.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (flip) begin
      lvl_d = s2_q;
    end else if (diff) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quokka_reset_sequencer.sv
// quokka_reset_sequencer: POR/button/soft reset pulse generator.
// Define QUOKKA_RESET_WATCHDOG_EN to add the watchdog trigger.
module quokka_reset_sequencer
  import quokka_reset_pkg::*;
#(
  parameter int POR_CYCLES      = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int DEBOUNCE_CYCLES = 4,
`ifdef QUOKKA_RESET_WATCHDOG_EN
  parameter int WDT_CYCLES      = 1024,
`endif
  parameter int CNT_W           = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ButtonIn,
  input  logic       SoftResetReq,
`ifdef QUOKKA_RESET_WATCHDOG_EN
  input  logic       WatchdogKick,
`endif
  output logic       InternalReset,
  output logic       Busy,
  output logic [1:0] ResetCause
);

  localparam logic [CNT_W-1:0] POR_LD  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_CYCLES - 1);

  state_e           state_q = ST_POR;
  logic [CNT_W-1:0] cnt_q   = POR_LD;
  logic             ir_q    = 1'b1;
  logic [1:0]       cause_q = CAUSE_POR;

  state_e           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ir_d;
  logic [1:0]       cause_d;

  logic             btn_rise;
  logic             wdt_exp;
  logic             trig;
  logic [1:0]       trig_cause;

  quokka_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk_i (Clock),
    .rst_i (Reset),
    .btn_i (ButtonIn),
    .rise_o(btn_rise)
  );

`ifdef QUOKKA_RESET_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES) + 1;
  localparam logic [WDT_W-1:0] WDT_LD = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q = WDT_LD;
  logic [WDT_W-1:0] wdt_d;

  assign wdt_exp = (state_q == ST_IDLE) && (wdt_q == '0)
                && !WatchdogKick;

  always_comb begin
    wdt_d = wdt_q;
    if (WatchdogKick || state_q != ST_IDLE) begin
      wdt_d = WDT_LD;
    end else if (wdt_q != '0) begin
      wdt_d = wdt_q - 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wdt_q <= WDT_LD;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_exp = 1'b0;
`endif

  // Button outranks soft request; watchdog is the fallback.
  always_comb begin
    trig       = 1'b1;
    trig_cause = CAUSE_BUTTON;
    if (btn_rise) begin
      trig_cause = CAUSE_BUTTON;
    end else if (SoftResetReq) begin
      trig_cause = CAUSE_SOFT;
    end else if (wdt_exp) begin
      trig_cause = CAUSE_WDT;
    end else begin
      trig = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_POR: begin
        ir_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          ir_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_IDLE: begin
        ir_d = 1'b0;
        if (trig) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          ir_d    = 1'b1;
          cause_d = trig_cause;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LD;
          ir_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_COOL: begin
        ir_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = POR_LD;
        ir_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_POR;
      cnt_q   <= POR_LD;
      ir_q    <= 1'b1;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      cause_q <= cause_d;
    end
  end

  assign InternalReset = ir_q;
  assign Busy          = state_q != ST_IDLE;
  assign ResetCause    = cause_q;

endmodule

// File: tb/tb_quokka_reset_sequencer.sv
// tb_quokka_reset_sequencer: directed + random stimulus against a
// timestamp-based reference model of the reset sequencer.
module tb_quokka_reset_sequencer;
  import quokka_reset_pkg::*;

  localparam int POR  = 16;
  localparam int HOLD = 8;
  localparam int COOL = 8;
  localparam int DB   = 4;
  localparam int WDT  = 32;
  localparam int MAXC = 4096;
`ifdef QUOKKA_RESET_WATCHDOG_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ButtonIn = 1'b0;
  logic       SoftResetReq = 1'b0;
  logic       kick = 1'b0;
  logic       InternalReset;
  logic       Busy;
  logic [1:0] ResetCause;

  always #5 clk = ~clk;

`ifdef QUOKKA_RESET_WATCHDOG_EN
  quokka_reset_sequencer #(.WDT_CYCLES(WDT)) dut (
    .Clock        (clk),
    .Reset        (Reset),
    .ButtonIn     (ButtonIn),
    .SoftResetReq (SoftResetReq),
    .WatchdogKick (kick),
    .InternalReset(InternalReset),
    .Busy         (Busy),
    .ResetCause   (ResetCause)
  );
`else
  quokka_reset_sequencer dut (
    .Clock        (clk),
    .Reset        (Reset),
    .ButtonIn     (ButtonIn),
    .SoftResetReq (SoftResetReq),
    .InternalReset(InternalReset),
    .Busy         (Busy),
    .ResetCause   (ResetCause)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pulses described by timestamps, not FSM states.
  int         cyc       = 0;
  int         ir_last   = POR - 1;
  int         idle_from = POR;
  logic [1:0] cause_m   = CAUSE_POR;
  logic       lvl_m     = 1'b0;
  int         win_start = 0;
  int         rst_edge  = -1;
  int         wrun      = 0;
  logic       btn_a [MAXC];
  logic       s2a   [MAXC];

  task automatic chk(input string tag, input logic [1:0] got,
                     input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d",
               tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic s,
                      input logic k, input logic r);
    logic idle, flip, rise, wexp;
    ButtonIn     = b;
    SoftResetReq = s;
    kick         = k;
    Reset        = r;
    btn_a[cyc]   = b;
    if (cyc - 2 <= rst_edge) s2a[cyc] = 1'b0;
    else                     s2a[cyc] = btn_a[cyc-2];
    #2;
    chk("irst",  {1'b0, InternalReset}, {1'b0, cyc <= ir_last});
    chk("busy",  {1'b0, Busy},          {1'b0, cyc < idle_from});
    chk("cause", ResetCause,            cause_m);
    idle = cyc >= idle_from;
    flip = 1'b0;
    if (cyc - (DB - 1) >= win_start) begin
      flip = 1'b1;
      for (int i = 0; i < DB; i++)
        if (s2a[cyc-i] == lvl_m) flip = 1'b0;
    end
    rise = flip && !lvl_m;
    wexp = WDT_EN && idle && !k && (wrun == WDT - 1);
    if (r) begin
      ir_last   = cyc + POR;
      idle_from = cyc + POR + 1;
      cause_m   = CAUSE_POR;
    end else if (idle && (rise || s || wexp)) begin
      ir_last   = cyc + HOLD;
      idle_from = cyc + HOLD + COOL + 1;
      cause_m   = rise ? CAUSE_BUTTON : (s ? CAUSE_SOFT : CAUSE_WDT);
    end
    if (r) begin
      lvl_m     = 1'b0;
      win_start = cyc + 1;
      rst_edge  = cyc;
    end else if (flip) begin
      lvl_m     = !lvl_m;
      win_start = cyc + 1;
    end
    if (r || !idle || k) wrun = 0;
    else                 wrun++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int   left;
    logic bcur;
    // Power-up with Reset low throughout.
    run(1'b0, 40);
    // Soft pulse, retry inside cooldown, retry after cooldown.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 9);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 7);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 30);
    chk("soft_cause", ResetCause, CAUSE_SOFT);
    // Short glitches must be filtered.
    for (int w = 1; w < DB; w++) begin
      run(1'b1, w);
      run(1'b0, 12);
    end
    // Long press, release, re-press.
    run(1'b1, 200);
    run(1'b0, 30);
    run(1'b1, 30);
    run(1'b0, 30);
    chk("btn_cause", ResetCause, CAUSE_BUTTON);
    // Debounced edge coincides with a soft request.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 30);
    run(1'b1, DB + 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run(1'b1, 20);
    run(1'b0, 30);
    chk("same_cause", ResetCause, CAUSE_BUTTON);
    // Reset in the middle of a hold pulse.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 25);
    chk("por_cause", ResetCause, CAUSE_POR);
`ifdef QUOKKA_RESET_WATCHDOG_EN
    run(1'b0, 60);
    chk("wdt_cause", ResetCause, CAUSE_WDT);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      run(1'b0, 19);
    end
`endif
    // Randomised traffic.
    bcur = 1'b0;
    left = 10;
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        bcur = !bcur;
        if ($urandom_range(0, 3) == 0) left = $urandom_range(1, DB - 1);
        else                           left = $urandom_range(DB, 40);
      end
      left--;
      step(bcur, $urandom_range(0, 15) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
